// File: rtl/gmsk_pkg.sv
// Shared definitions for the GMSK burst receive path.
//   ADC_WIDTH     - raw ADC sample width (offset binary)
//   ADC_OFFSET    - raw code representing zero amplitude
//   SAMPLE_WIDTH  - signed sample width after offset removal
//   rx_state_t    - burst receiver FSM states
//   popcount16    - number of set bits in a 16-bit word
//   adc_to_signed - offset-binary ADC code to signed sample
package gmsk_pkg;

  localparam int unsigned ADC_WIDTH    = 6;
  localparam int unsigned ADC_OFFSET   = 31;
  localparam int unsigned SAMPLE_WIDTH = 7;
  localparam int unsigned PROD_WIDTH   = 2 * SAMPLE_WIDTH - 1;
  localparam int unsigned DIFF_WIDTH   = PROD_WIDTH + 1;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
  typedef logic signed [PROD_WIDTH-1:0]   prod_t;
  typedef logic signed [DIFF_WIDTH-1:0]   diff_t;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    PAYLOAD
  } rx_state_t;

  function automatic logic [4:0] popcount16(input logic [15:0] value);
    logic [4:0] count;
    count = '0;
    for (int k = 0; k < 16; k++) begin
      count = count + 5'(value[k]);
    end
    return count;
  endfunction

  // 0..63 maps to -31..+32.
  function automatic sample_t adc_to_signed(input logic [ADC_WIDTH-1:0] raw);
    return sample_t'({1'b0, raw}) - sample_t'(ADC_OFFSET);
  endfunction

endpackage

// File: rtl/gmsk_diff_detect.sv
// One-symbol differential phase detector.
//   clock, reset_n - system clock, asynchronous active-low reset
//   adc_zero/one   - offset-binary I/Q samples, qualified by iq_valid
//   clear          - restart: empties the delay line, phase counter and pipeline
//   dec_bit        - decision (1 when d > 0), valid while dec_strobe is high
//   dec_strobe     - a decision leaves the product stage this cycle
// Pipeline: stage 1 registers the current and one-symbol-old samples on the
// decision phase, stage 2 registers both products; the sign of the difference
// is combinational here and is registered by the parent as stage 3.
module gmsk_diff_detect
  import gmsk_pkg::*;
#(
  parameter int unsigned SAMPLES_PER_SYMBOL = 8,
  parameter int unsigned DECISION_PHASE     = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [ADC_WIDTH-1:0] adc_zero,
  input  logic [ADC_WIDTH-1:0] adc_one,
  input  logic                 iq_valid,
  input  logic                 clear,
  output logic                 dec_bit,
  output logic                 dec_strobe
);

  localparam int unsigned PhaseW = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;

  sample_t i_in, q_in;
  assign i_in = adc_to_signed(adc_zero);
  assign q_in = adc_to_signed(adc_one);

  // hist[k] holds the sample taken k+1 valid samples ago; the last entry is n-SPS.
  sample_t hist_i_q [SAMPLES_PER_SYMBOL];
  sample_t hist_q_q [SAMPLES_PER_SYMBOL];
  logic [PhaseW-1:0] phase_q;

  logic decide;
  assign decide = iq_valid && (phase_q == PhaseW'(DECISION_PHASE));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < int'(SAMPLES_PER_SYMBOL); k++) begin
        hist_i_q[k] <= '0;
        hist_q_q[k] <= '0;
      end
      phase_q <= '0;
    end else if (clear) begin
      for (int k = 0; k < int'(SAMPLES_PER_SYMBOL); k++) begin
        hist_i_q[k] <= '0;
        hist_q_q[k] <= '0;
      end
      phase_q <= '0;
    end else if (iq_valid) begin
      hist_i_q[0] <= i_in;
      hist_q_q[0] <= q_in;
      for (int k = 1; k < int'(SAMPLES_PER_SYMBOL); k++) begin
        hist_i_q[k] <= hist_i_q[k-1];
        hist_q_q[k] <= hist_q_q[k-1];
      end
      if (phase_q == PhaseW'(SAMPLES_PER_SYMBOL - 1)) begin
        phase_q <= '0;
      end else begin
        phase_q <= phase_q + PhaseW'(1);
      end
    end
  end

  // Stage 1: current and delayed samples captured on the decision phase.
  sample_t s1_i_q, s1_q_q, s1_ip_q, s1_qp_q;
  logic    s1_valid_q;
  // Stage 2: products.
  prod_t   s2_pa_q, s2_pb_q;
  logic    s2_valid_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_i_q     <= '0;
      s1_q_q     <= '0;
      s1_ip_q    <= '0;
      s1_qp_q    <= '0;
      s1_valid_q <= 1'b0;
      s2_pa_q    <= '0;
      s2_pb_q    <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      // A restart drops any decision already in flight.
      s1_valid_q <= decide && !clear;
      s2_valid_q <= s1_valid_q && !clear;
      if (decide) begin
        s1_i_q  <= i_in;
        s1_q_q  <= q_in;
        s1_ip_q <= hist_i_q[SAMPLES_PER_SYMBOL-1];
        s1_qp_q <= hist_q_q[SAMPLES_PER_SYMBOL-1];
      end
      if (s1_valid_q) begin
        s2_pa_q <= PROD_WIDTH'(s1_q_q) * PROD_WIDTH'(s1_ip_q);
        s2_pb_q <= PROD_WIDTH'(s1_i_q) * PROD_WIDTH'(s1_qp_q);
      end
    end
  end

  diff_t diff;
  assign diff       = DIFF_WIDTH'(s2_pa_q) - DIFF_WIDTH'(s2_pb_q);
  // d == 0 resolves to 0.
  assign dec_bit    = (diff > diff_t'(0));
  assign dec_strobe = s2_valid_q;

endmodule

// File: rtl/gmsk_rx_burst.sv
// GMSK burst receiver: differential detection, sync-word hunt, payload output.
//   clock, reset_n     - system clock, asynchronous active-low reset
//   adc_zero, adc_one  - offset-binary I/Q samples (31 = zero), qualified by iq_valid
//   arm                - single-cycle start (or restart) of a sync hunt
//   armed              - receiver busy with a burst (HUNT or PAYLOAD)
//   sync_found         - one-cycle pulse on sync match
//   bit_out, bit_valid - payload bit stream
//   burst_done         - one-cycle pulse with the last payload bit
module gmsk_rx_burst
  import gmsk_pkg::*;
#(
  parameter int unsigned SAMPLES_PER_SYMBOL = 8,
  parameter int unsigned DECISION_PHASE     = 4,
  parameter logic [15:0] SYNC_WORD          = 16'hB5C3,
  parameter int unsigned SYNC_TOLERANCE     = 1,
  parameter int unsigned PAYLOAD_BITS       = 148
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [ADC_WIDTH-1:0] adc_zero,
  input  logic [ADC_WIDTH-1:0] adc_one,
  input  logic                 iq_valid,
  input  logic                 arm,
  output logic                 armed,
  output logic                 sync_found,
  output logic                 bit_out,
  output logic                 bit_valid,
  output logic                 burst_done
);

  localparam int unsigned PayCntW = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  logic dec_bit, dec_strobe;

  gmsk_diff_detect #(
    .SAMPLES_PER_SYMBOL (SAMPLES_PER_SYMBOL),
    .DECISION_PHASE     (DECISION_PHASE)
  ) u_diff_detect (
    .clock      (clock),
    .reset_n    (reset_n),
    .adc_zero   (adc_zero),
    .adc_one    (adc_one),
    .iq_valid   (iq_valid),
    .clear      (arm),
    .dec_bit    (dec_bit),
    .dec_strobe (dec_strobe)
  );

  rx_state_t          state_q;
  logic [15:0]        sync_q;
  logic [PayCntW-1:0] pay_cnt_q;
  logic               armed_q, sync_found_q, bit_out_q, bit_valid_q, burst_done_q;

  // Compared on the registered shift register, so a match is seen one cycle
  // after the matching decision lands.
  logic sync_match;
  assign sync_match = int'(popcount16(sync_q ^ SYNC_WORD)) <= int'(SYNC_TOLERANCE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      pay_cnt_q    <= '0;
      armed_q      <= 1'b0;
      sync_found_q <= 1'b0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      sync_found_q <= 1'b0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      burst_done_q <= 1'b0;
      // Lags the state by one cycle so armed is still high alongside burst_done.
      armed_q      <= (state_q != IDLE);

      if (arm) begin
        state_q   <= HUNT;
        sync_q    <= '0;
        pay_cnt_q <= '0;
        armed_q   <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
          end

          HUNT: begin
            if (sync_match) begin
              sync_found_q <= 1'b1;
              state_q      <= PAYLOAD;
              pay_cnt_q    <= '0;
              // A decision arriving with the match is already payload bit 0.
              if (dec_strobe) begin
                bit_out_q   <= dec_bit;
                bit_valid_q <= 1'b1;
                if (PAYLOAD_BITS == 1) begin
                  burst_done_q <= 1'b1;
                  state_q      <= IDLE;
                end else begin
                  pay_cnt_q <= PayCntW'(1);
                end
              end
            end else if (dec_strobe) begin
              sync_q <= {sync_q[14:0], dec_bit};
            end
          end

          PAYLOAD: begin
            if (dec_strobe) begin
              bit_out_q   <= dec_bit;
              bit_valid_q <= 1'b1;
              if (pay_cnt_q == PayCntW'(PAYLOAD_BITS - 1)) begin
                burst_done_q <= 1'b1;
                state_q      <= IDLE;
              end else begin
                pay_cnt_q <= pay_cnt_q + PayCntW'(1);
              end
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign armed      = armed_q;
  assign sync_found = sync_found_q;
  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign burst_done = burst_done_q;

endmodule

// File: tb/tb_gmsk_rx_burst.sv
// Directed bench for gmsk_rx_burst: MSK-modulated loopback bursts, expected
// payload bits queued at the decision sample and checked as they emerge.
module tb_gmsk_rx_burst;

  localparam int     Pay   = 148;
  localparam int     Nbits = 32 + Pay;
  localparam real    Pi    = 3.14159265358979;
  localparam logic [15:0] SyncW = 16'hB5C3;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic [5:0] adc_zero = 6'd31;
  logic [5:0] adc_one = 6'd31;
  logic       iq_valid = 1'b0;
  logic       arm = 1'b0;
  logic       armed, sync_found, bit_out, bit_valid, burst_done;

  gmsk_rx_burst u_dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .adc_zero   (adc_zero),
    .adc_one    (adc_one),
    .iq_valid   (iq_valid),
    .arm        (arm),
    .armed      (armed),
    .sync_found (sync_found),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .burst_done (burst_done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic b;
    int   cycle;
    logic last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   sync_cnt = 0, sync_cyc = 0, bit_cnt = 0, done_cnt = 0;
  int   exp_sync_cyc = 0;
  logic payload[Pay];
  logic tx_bits[Nbits];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (bit_valid === 1'b1) begin
        bit_cnt++;
        chk("bit_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("bit_value", 32'(bit_out), 32'(mon_e.b));
          chk("bit_latency", cyc, mon_e.cycle);
          chk("burst_done_at_bit", 32'(burst_done), 32'(mon_e.last));
        end
      end
      if (sync_found === 1'b1) begin
        sync_cnt++;
        sync_cyc = cyc;
      end
      if (burst_done === 1'b1) begin
        done_cnt++;
        chk("burst_done_with_bit", 32'(bit_valid), 32'd1);
        chk("armed_at_done", 32'(armed), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_phase(input int p);
    real a;
    a = real'(p) * Pi / 16.0;
    adc_zero = 6'($rtoi(31.0 * $cos(a) + 31.5));
    adc_one  = 6'($rtoi(31.0 * $sin(a) + 31.5));
    iq_valid = 1'b1;
  endtask

  task automatic feed_zero(input int n);
    adc_zero = 6'd31;
    adc_one  = 6'd31;
    iq_valid = 1'b1;
    repeat (n) tick();
    iq_valid = 1'b0;
  endtask

  // Arms the receiver and sends preamble, sync (xor flip) and the first
  // stop_after payload bits. Phase steps +-pi/16 per sample so each decision
  // sample is exactly +-pi/2 from the one a symbol earlier.
  task automatic send_burst(input logic [15:0] flip, input int gap, input int stop_after,
                            input logic expect_sync);
    int p, k, n_end, last_k;
    for (int j = 0; j < 16; j++) tx_bits[j] = (j % 2 == 1);
    for (int j = 0; j < 16; j++) tx_bits[16+j] = SyncW[15-j] ^ flip[15-j];
    for (int j = 0; j < Pay; j++) tx_bits[32+j] = payload[j];
    bit_cnt  = 0;
    sync_cnt = 0;
    done_cnt = 0;
    iq_valid = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("armed_after_arm", 32'(armed), 32'd1);
    last_k = 32 + stop_after - 1;
    n_end  = 12 + 8 * last_k + ((stop_after == Pay) ? 8 : 0);
    p = 0;
    for (int n = 0; n <= n_end; n++) begin
      if (n >= 5) begin
        k = (n - 5) / 8;
        if (k >= Nbits || tx_bits[k]) p = (p + 1) % 32;
        else p = (p + 31) % 32;
      end
      drive_phase(p);
      if (n >= 12 && (n - 12) % 8 == 0) begin
        k = (n - 12) / 8;
        if (expect_sync && k == 31) exp_sync_cyc = cyc + 4;
        if (expect_sync && k >= 32 && k < 32 + stop_after)
          sb.push_back('{b: tx_bits[k], cycle: cyc + 3, last: (k == Nbits - 1)});
      end
      tick();
      for (int g = 0; g < gap; g++) begin
        iq_valid = 1'b0;
        tick();
      end
    end
    iq_valid = 1'b0;
  endtask

  task automatic check_full(input string tag);
    repeat (8) tick();
    chk({tag, "_queue_drained"}, sb.size(), 0);
    chk({tag, "_sync_count"}, sync_cnt, 1);
    chk({tag, "_sync_cycle"}, sync_cyc, exp_sync_cyc);
    chk({tag, "_bit_count"}, bit_cnt, Pay);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_armed_after"}, 32'(armed), 32'd0);
  endtask

  initial begin
    logic [6:0] lfsr;
    lfsr = 7'h7F;
    for (int j = 0; j < Pay; j++) begin
      payload[j] = lfsr[6];
      lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end

    // Reset with mid-scale inputs and iq_valid high.
    iq_valid = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {27'd0, armed, sync_found, bit_out, bit_valid, burst_done}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      chk("idle_outputs", {27'd0, armed, sync_found, bit_out, bit_valid, burst_done}, 32'd0);
    end
    tick();
    iq_valid = 1'b0;

    send_burst(16'h0000, 0, Pay, 1'b1);
    check_full("clean");

    send_burst(16'h0100, 0, Pay, 1'b1);
    check_full("flip1");

    send_burst(16'h8001, 0, 0, 1'b0);
    repeat (20) tick();
    chk("flip2_no_sync", sync_cnt, 0);
    chk("flip2_no_bits", bit_cnt, 0);
    chk("flip2_armed", 32'(armed), 32'd1);

    send_burst(16'h0000, 2, Pay, 1'b1);
    check_full("sparse");

    // Abort with arm once payload bit 50 is due.
    send_burst(16'h0000, 0, 50, 1'b1);
    repeat (4) tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    feed_zero(300);
    chk("abort_bit_count", bit_cnt, 50);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_armed", 32'(armed), 32'd1);
    chk("abort_queue", sb.size(), 0);

    send_burst(16'h0000, 0, Pay, 1'b1);
    check_full("resend");

    // Reset while payload bit 19 is on the outputs.
    send_burst(16'h0000, 0, 20, 1'b1);
    repeat (2) tick();
    chk("rst_bit_present", 32'(bit_valid), 32'd1);
    void'(sb.pop_back());
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_outputs", {27'd0, armed, sync_found, bit_out, bit_valid, burst_done}, 32'd0);
    tick();
    reset_n = 1'b1;
    feed_zero(200);
    chk("rst_bit_count", bit_cnt, 19);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_queue", sb.size(), 0);

    send_burst(16'h0000, 0, Pay, 1'b1);
    check_full("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gmsk_rx_burst.md
# gmsk_rx_burst

Burst receiver for the GMSK link, and the receive-side counterpart of the burst transmitter. It takes offset-binary 6-bit I/Q ADC samples and performs one-symbol differential phase detection at a fixed decision phase. It hunts for a 16-bit sync word within a Hamming tolerance, then emits a fixed-length payload as a bit stream with a valid strobe. It sits between the ADC capture registers and the burst deframer / bit sink.

## Interface
- SAMPLES_PER_SYMBOL, 8 — ADC samples per symbol; ≥ 2; also the differential delay depth.
- DECISION_PHASE, 4 — sample index within a symbol (0..SAMPLES_PER_SYMBOL-1) on which a bit decision is made.
- SYNC_WORD, 16'hB5C3 — sync pattern, MSB received first.
- SYNC_TOLERANCE, 1 — maximum bit errors accepted in the sync match (0..3).
- PAYLOAD_BITS, 148 — bits emitted per burst after sync (1..1023).

Ports:
- clock  in  1  — single system clock; all logic on its rising edge.
- reset_n  in  1  — asynchronous, active-low reset.
- adc_zero  in  6  — in-phase sample, offset binary, 31 = zero.
- adc_one  in  6  — quadrature sample, offset binary, 31 = zero.
- iq_valid  in  1  — adc_zero/adc_one carry a new sample this cycle.
- arm  in  1  — single-cycle request to start hunting.
- armed  out  1  — high in HUNT and PAYLOAD.
- sync_found  out  1  — one-cycle pulse when the sync word is matched.
- bit_out  out  1  — payload bit.
- bit_valid  out  1  — bit_out is valid this cycle; PAYLOAD only.
- burst_done  out  1  — one-cycle pulse coincident with the last bit_valid.

## Operation
- Sample conversion:
  - i = adc_zero − 31 and q = adc_one − 31, as 7-bit signed values (range −31..+32).
- Symbol delay line:
  - SAMPLES_PER_SYMBOL-deep history of (i,q), advanced only on iq_valid.
  - Cleared to zero on reset and on arm.
- Decision:
  - d = q[n]·i[n−SPS] − i[n]·q[n−SPS], computed with 13-bit products and a 14-bit signed difference.
  - bit = 1 iff d > 0. d = 0 gives bit = 0.
- Phase counter:
  - Modulo SAMPLES_PER_SYMBOL; increments per iq_valid.
  - Cleared on arm.
  - A decision is made on the sample where counter == DECISION_PHASE.
- States:
  - IDLE: outputs quiet; arm → HUNT.
  - HUNT: each decision shifts into a 16-bit sync register. When popcount(sync_reg ^ SYNC_WORD) ≤ SYNC_TOLERANCE, pulse sync_found and go to PAYLOAD with the payload counter at 0.
  - PAYLOAD: each decision is emitted on bit_out with bit_valid, and the payload counter increments. On bit PAYLOAD_BITS−1, burst_done pulses and the state goes to IDLE.
- Sync bits are never emitted. The first payload bit is the first decision after the matching one.
- arm while in HUNT or PAYLOAD aborts the burst and restarts HUNT. Counters, the delay line and the sync register are cleared, and burst_done is not pulsed.
- iq_valid low stalls the pipeline inputs and all counters in every state.

## Timing
- Reset value of every output is 0; the state is IDLE.
- Reset is honoured mid-burst with no further bit_valid.
- Pipeline:
  - Stage 1 registers i/q.
  - Stage 2 registers the products.
  - Stage 3 registers the decision.
- bit_valid/bit_out appear 3 cycles after the iq_valid cycle of the decision sample.
- sync_found appears 4 cycles after the decision sample (match compared on the registered sync register).
- A decision whose stage-3 result lands in the same cycle as sync_found is treated as a payload bit, so back-to-back samples lose no bits.
- armed rises 1 cycle after arm and falls in the cycle after burst_done.
- A decision in flight when arm is taken is discarded.

## Structure
- Shared package gmsk_pkg:
  - ADC_WIDTH = 6, ADC_OFFSET = 31, SAMPLE_WIDTH = 7.
  - rx_state_t enum {IDLE, HUNT, PAYLOAD}.
  - popcount16 function.
- Sub-module gmsk_diff_detect: offset removal, delay line, products, sign decision, phase counter. Outputs a decision bit and a decision strobe.
- Top level: FSM, sync register, payload counter.

## Test plan
- Reset with adc inputs at 31/31 and iq_valid high → all outputs 0 and armed 0 for 100 cycles.
- Transmit-loopback stimulus: SAMPLES_PER_SYMBOL=8, preamble 0x5555, SYNC_WORD 0xB5C3, 148-bit PRBS payload → sync_found once, then 148 bit_valid pulses matching the PRBS, burst_done on the 148th, armed low afterwards.
- Sync word with 1 flipped bit → match. With 2 flipped bits and SYNC_TOLERANCE=1 → no sync_found, armed stays 1.
- iq_valid toggling 1-of-3 cycles throughout the burst → identical bit sequence, with each bit_valid 3 cycles after its decision sample.
- arm pulse at payload bit 50 → no burst_done, bit_valid stops. A re-sent burst is then received in full.
- reset_n low for 1 cycle at payload bit 20 → outputs 0 asynchronously, state IDLE, and no bit_valid until the next arm.
